// File: rtl/keccak_round_ctrl.sv
// Sequences padded blocks into the Keccak-f datapath: clear/absorb on accept, then NR rounds.
// Latency: NR+1 cycles from block accept to next accept or out_valid.
// Backpressure: f_ack only in WAIT; out_valid holds in DONE until out_ack.
module keccak_round_ctrl #(
    parameter int NR = 24,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          blk_ready,
    input  logic          blk_last,
    output logic          f_ack,
    output logic          state_clr,
    output logic          absorb,
    output logic          round_en,
    output logic [RW-1:0] round_idx,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ack
);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [RW-1:0] LAST_IDX = RW'(NR - 1);

    logic [1:0]    state;
    logic          first;
    logic          last_r;
    logic [RW-1:0] idx;
    logic          valid_q;

    logic accept;

    // Gated by reset so the padder never sees an ack while the controller is held in reset.
    assign accept    = (state == S_WAIT) & blk_ready & reset;
    assign f_ack     = accept;
    assign absorb    = accept;
    assign state_clr = accept & first;
    assign round_en  = (state == S_ROUND);
    assign round_idx = idx;
    assign busy      = (state != S_WAIT);
    assign out_valid = valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_WAIT;
            first   <= 1'b1;
            last_r  <= 1'b0;
            idx     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (blk_ready) begin
                        last_r <= blk_last;
                        first  <= 1'b0;
                        idx    <= '0;
                        state  <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (idx == LAST_IDX) begin
                        idx <= '0;
                        if (last_r) begin
                            state   <= S_DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    // Returning to WAIT re-arms state_clr for the next message.
                    if (out_ack) begin
                        valid_q <= 1'b0;
                        first   <= 1'b1;
                        state   <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule
